// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the clock-pattern generator.
//   state_t       : FSM states (IDLE / LOW / HIGH)
//   LFSR_TAPS     : Galois tap mask for x^16+x^14+x^13+x^11+1
//   DEF_*_C       : period / high time after reset
//   cfg_is_legal  : config legality check (guarantees low time >= 1)
//   lfsr_step     : one Galois LFSR step
package clk_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam int unsigned DEF_PERIOD_C = 10;
    localparam int unsigned DEF_HIGH_C   = 5;

    // jitter < period - high keeps the shortest possible low phase at 1 cycle.
    function automatic logic cfg_is_legal(input int unsigned period,
                                          input int unsigned high,
                                          input int unsigned jitter);
        return (period >= 2) && (high >= 1) && (high <= period - 1) &&
               (jitter < period - high);
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/clk_gen_lfsr.sv
// 16-bit Galois LFSR used as the jitter source.
//   clk    : system clock
//   load_i : synchronous reload of SEED (highest priority)
//   step_i : advance one step
//   cur_o  : low OUT_W bits of the current state
//   next_o : low OUT_W bits of the state after one step
module clk_gen_lfsr
    import clk_gen_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int unsigned OUT_W = 9
) (
    input  logic             clk,
    input  logic             load_i,
    input  logic             step_i,
    output logic [OUT_W-1:0] cur_o,
    output logic [OUT_W-1:0] next_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = lfsr_step(lfsr_q);

    always_ff @(posedge clk) begin
        if (load_i) begin
            lfsr_q <= SEED;
        end else if (step_i) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign cur_o  = lfsr_q[OUT_W-1:0];
    assign next_o = lfsr_d[OUT_W-1:0];

endmodule

// File: rtl/clk_gen_ctrl.sv
// Run-time configurable divided-clock generator with low-phase jitter and
// a built-in period measurement unit.
//   clk, rst          : system clock, synchronous active-high reset
//   en                : run request (sampled in IDLE and at period end)
//   cfg_valid/ready   : config handshake; cfg_period/high/jitter payload
//   cfg_err           : 1-cycle pulse when an offered config is illegal
//   clk_out           : generated clock (registered)
//   period_start      : pulse in the first cycle clk_out reads 1
//   meas_valid/period : cycles between the last two clk_out rising edges
//   busy              : FSM not idle
//
// state | meaning
// IDLE  | stopped, clk_out=0, pending config applied immediately
// LOW   | low phase, cnt_q counts down the drawn low length
// HIGH  | high phase, cnt_q counts down the active high time
module clk_gen_ctrl
    import clk_gen_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned JIT_W      = 8,
    parameter int unsigned DEF_PERIOD = DEF_PERIOD_C,
    parameter int unsigned DEF_HIGH   = DEF_HIGH_C,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [JIT_W-1:0] cfg_jitter,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             period_start,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_period,
    output logic             busy
);

    // Low length can reach 2*(period-high)-1, so the phase counter gets a spare bit.
    localparam int unsigned CW1   = CNT_W + 1;
    localparam int unsigned RAW_W = JIT_W + 1;

    state_t           state_q;
    logic [CW1-1:0]   cnt_q;
    logic [CNT_W-1:0] act_period_q, act_high_q;
    logic [JIT_W-1:0] act_jitter_q;
    logic [CNT_W-1:0] pend_period_q, pend_high_q;
    logic [JIT_W-1:0] pend_jitter_q;
    logic             pend_valid_q;
    logic             clk_out_q, period_start_q, meas_valid_q, cfg_err_q;
    logic             armed_q;
    logic [CNT_W-1:0] meas_cnt_q, meas_period_q;

    logic             cfg_legal, cfg_take, cfg_bad;
    logic             boundary;
    logic [CNT_W-1:0] eff_period, eff_high;
    logic [JIT_W-1:0] eff_jitter;
    logic [RAW_W-1:0] raw_cur, raw_next, raw, two_j;
    logic [CW1-1:0]   base_len, low_len;
    logic [CNT_W-1:0] meas_inc;

    assign cfg_legal = cfg_is_legal(32'(cfg_period), 32'(cfg_high), 32'(cfg_jitter));
    assign cfg_take  = cfg_valid & ~pend_valid_q & cfg_legal;
    assign cfg_bad   = cfg_valid & ~pend_valid_q & ~cfg_legal;
    assign boundary  = (state_q == HIGH) && (cnt_q == CW1'(1));

    clk_gen_lfsr #(
        .SEED  (SEED),
        .OUT_W (RAW_W)
    ) u_lfsr (
        .clk    (clk),
        .load_i (rst),
        .step_i (boundary),
        .cur_o  (raw_cur),
        .next_o (raw_next)
    );

    // The low length of a new period is drawn from the config that will be
    // active for it (pending wins, since it is applied on this same edge).
    // At a boundary the LFSR steps on this edge, so the stepped value is used;
    // leaving IDLE draws from the current value without stepping.
    always_comb begin
        eff_period = pend_valid_q ? pend_period_q : act_period_q;
        eff_high   = pend_valid_q ? pend_high_q   : act_high_q;
        eff_jitter = pend_valid_q ? pend_jitter_q : act_jitter_q;
        raw        = (state_q == IDLE) ? raw_cur : raw_next;
        two_j      = {eff_jitter, 1'b0};
        base_len   = CW1'(eff_period) - CW1'(eff_high);
        low_len    = base_len;
        if (raw <= two_j) begin
            low_len = base_len + CW1'(raw) - CW1'(eff_jitter);
        end
    end

    assign meas_inc = (meas_cnt_q == '1) ? meas_cnt_q : meas_cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            act_period_q   <= CNT_W'(DEF_PERIOD);
            act_high_q     <= CNT_W'(DEF_HIGH);
            act_jitter_q   <= '0;
            pend_period_q  <= '0;
            pend_high_q    <= '0;
            pend_jitter_q  <= '0;
            pend_valid_q   <= 1'b0;
            clk_out_q      <= 1'b0;
            period_start_q <= 1'b0;
            meas_valid_q   <= 1'b0;
            cfg_err_q      <= 1'b0;
            armed_q        <= 1'b0;
            meas_cnt_q     <= '0;
            meas_period_q  <= '0;
        end else begin
            period_start_q <= 1'b0;
            meas_valid_q   <= 1'b0;
            cfg_err_q      <= cfg_bad;

            if (cfg_take) begin
                pend_period_q <= cfg_period;
                pend_high_q   <= cfg_high;
                pend_jitter_q <= cfg_jitter;
                pend_valid_q  <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    clk_out_q <= 1'b0;
                    armed_q   <= 1'b0;
                    if (pend_valid_q) begin
                        act_period_q <= pend_period_q;
                        act_high_q   <= pend_high_q;
                        act_jitter_q <= pend_jitter_q;
                        pend_valid_q <= 1'b0;
                    end
                    if (en) begin
                        state_q <= LOW;
                        cnt_q   <= low_len;
                    end
                end

                LOW: begin
                    if (cnt_q == CW1'(1)) begin
                        state_q        <= HIGH;
                        clk_out_q      <= 1'b1;
                        period_start_q <= 1'b1;
                        cnt_q          <= CW1'(act_high_q);
                        // Rising edge: restart the measurement; the first edge
                        // after IDLE has no valid reference so it only arms.
                        meas_cnt_q     <= CNT_W'(1);
                        meas_valid_q   <= armed_q;
                        if (armed_q) begin
                            meas_period_q <= meas_cnt_q;
                        end
                        armed_q        <= 1'b1;
                    end else begin
                        cnt_q      <= cnt_q - CW1'(1);
                        meas_cnt_q <= meas_inc;
                    end
                end

                HIGH: begin
                    meas_cnt_q <= meas_inc;
                    if (boundary) begin
                        clk_out_q <= 1'b0;
                        if (pend_valid_q) begin
                            act_period_q <= pend_period_q;
                            act_high_q   <= pend_high_q;
                            act_jitter_q <= pend_jitter_q;
                            pend_valid_q <= 1'b0;
                        end
                        if (en) begin
                            state_q <= LOW;
                            cnt_q   <= low_len;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW1'(1);
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    clk_out_q <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready    = ~pend_valid_q;
    assign cfg_err      = cfg_err_q;
    assign clk_out      = clk_out_q;
    assign period_start = period_start_q;
    assign meas_valid   = meas_valid_q;
    assign meas_period  = meas_period_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: doc/clk_gen_ctrl.md
Name: clk_gen_ctrl

Overview:
Synthesizable, run-time configurable clock-pattern generator and controller. Derives a divided clock clk_out from the system clock with a programmable period, high time and bounded pseudo-random jitter on the low phase. New settings arrive on a valid/ready config port and take effect only at period boundaries. A built-in measurement unit reports the period of every clk_out cycle in system-clock cycles.

Parameters:
CNT_W, 16, width of period/high/measurement counters
JIT_W, 8, width of jitter magnitude field (cycles)
DEF_PERIOD, 10, period after reset (cycles)
DEF_HIGH, 5, high time after reset (cycles)
SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
en  in  1  run request
cfg_valid  in  1  config offer
cfg_ready  out  1  config slot free
cfg_period  in  CNT_W  period in cycles
cfg_high  in  CNT_W  high time in cycles
cfg_jitter  in  JIT_W  max jitter J, cycles (0 = none)
cfg_err  out  1  1-cycle pulse: offered config rejected
clk_out  out  1  generated clock, registered
period_start  out  1  1-cycle pulse in the cycle clk_out first reads 1
meas_valid  out  1  1-cycle pulse, meas_period updated
meas_period  out  CNT_W  cycles between last two clk_out rising edges, saturating at all-ones
busy  out  1  state != IDLE

Behaviour:
- Reset (one clk with rst=1): state IDLE; clk_out=0; period_start=0; meas_valid=0; meas_period=0; cfg_err=0; cfg_ready=1; active config={DEF_PERIOD, DEF_HIGH, 0}; pending slot empty; LFSR=SEED. Reset mid-period aborts immediately and discards any pending config.
- States: IDLE, LOW, HIGH. clk_out=1 only in HIGH.
- IDLE->LOW when en=1; the low counter loads L = period - high + off.
- LOW lasts exactly L cycles, then HIGH; period_start pulses on the first HIGH cycle.
- HIGH lasts exactly `high` cycles. At its end, the boundary action is:
  - apply pending config (if any);
  - advance the LFSR;
  - if en=1, go to LOW with a fresh L; otherwise go to IDLE.
- en deassert never truncates a period: the current period completes first. en reasserted before the period ends means no gap.
- Jitter: raw = LFSR[JIT_W:0].
  - If raw <= 2J, off = raw - J.
  - Otherwise off = 0.
  - off is drawn once per period at the boundary (and at IDLE->LOW).
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Steps once per boundary, not every clk.
- Config legality: cfg_period >= 2, 1 <= cfg_high <= cfg_period-1, cfg_jitter < cfg_period - cfg_high (guarantees L >= 1).
- Config handshake:
  - Accept on cfg_valid & cfg_ready & legal: store in the pending slot; cfg_ready=0 next cycle until the slot is applied.
  - Illegal offer while cfg_ready=1: cfg_err pulses the next cycle, nothing is stored, cfg_ready stays 1.
- Config apply timing:
  - In IDLE, pending config is applied on the cycle after acceptance.
  - A config accepted in the same cycle as a boundary is applied at the following boundary, never mid-period.
- Measurement:
  - A free-running counter is cleared on each clk_out rising edge.
  - meas_valid/meas_period update on every rising edge except the first after leaving IDLE.
  - The counter saturates; it is not counted in IDLE.

Decomposition:
- Package clk_gen_pkg: state enum (IDLE/LOW/HIGH), LFSR tap constant 16'hB400, default period/high constants, legality-check function.
- One sub-module, clk_gen_lfsr: 16-bit Galois LFSR with step enable and synchronous seed load.

Test Plan:
- Defaults, en=1 after reset: clk_out low 5 / high 5 repeating. First meas_valid comes at the second rising edge with meas_period=10. period_start aligns with every rising edge.
- Mid-run legal config {8,2,0} accepted during a LOW phase:
  - cfg_ready=0 until the boundary;
  - old period completes (5/5), then low 6 / high 2;
  - meas_period sequence 10, 11 (5 high + 6 low), then 8 steadily.
- Illegal configs {1,1,0}, {10,0,0}, {10,5,5}: each gives a cfg_err pulse, timing unchanged, cfg_ready stays 1.
- Jitter {10,5,2}, 200 periods:
  - meas_period always within 8..12, high always 5;
  - exact sequence matches a bench LFSR reference model seeded with 16'hACE1.
- en dropped mid-LOW: the current low and high complete, then IDLE with clk_out=0 and busy=0. Re-enable resumes with low=5; no meas_valid on the first edge.
- rst asserted mid-HIGH with a config pending: next cycle clk_out=0, IDLE, cfg_ready=1. After en, the defaults (10/5) apply and the pending config is gone.
